fetch_redirect_controller: RTL and testbench
============================================

# fetch_redirect_controller

Owns the program counter and sequences instruction fetch for the pipeline. It applies taken-branch/jump redirects resolved in execute (`pc_source`, `branch_taken`) to the PC, and drives a single-outstanding request/ack instruction-memory port. It buffers responses against decode stalls and flushes the IF/ID and ID/EX registers on every redirect.

## Interface
- `RESET_PC`, default 32'h0000_0000, PC fetched first after reset
- `clk`  in  1  clock; all state updates on rising edge
- `rst_n`  in  1  reset; asynchronous, active-low
- `pc_source`  in  `PC_SRC_BITS_COUNT`  execute-stage next-PC selector
- `branch_taken`  in  1  execute-stage taken flag
- `ex_valid`  in  1  execute stage holds a valid instruction; qualifies `branch_taken`
- `ex_pc`, `ex_imm`, `ex_gpr`  in  32 each  PC, immediate and rs1 value of the execute instruction
- `stall`  in  1  IF/ID not accepting this cycle
- `imem_req`  out  1  fetch request (registered)
- `imem_addr`  out  32  fetch address (registered)
- `imem_ack`  in  1  transfer completes in a cycle with `imem_req && imem_ack`
- `imem_rdata`  in  32  instruction; valid with ack
- `if_valid`, `if_pc`, `if_instr`  out  1/32/32  fetch output register to IF/ID
- `flush_if_id`, `flush_id_ex`  out  1  combinational flush pulses
- `redirect_count`  out  32  redirects taken since reset; wraps

## Operation
- Redirect = `ex_valid & branch_taken`.
- Target by `pc_source`:
  - PC_PLUS_IMM: `ex_pc+ex_imm`.
  - GPR_PLUS_IMM: `(ex_gpr+ex_imm) & ~1`.
  - PC_PLUS_4: `ex_pc+4`.
  - All sums are mod 2^32.
- Redirect cycle:
  - `flush_if_id` = `flush_id_ex` = 1.
  - At the edge: PC ← target; output register and hold buffer cleared; `redirect_count` += 1.
  - Redirect overrides `stall`.
- FSM states:
  - IDLE: no request outstanding. If issue is allowed (`stall`=0, hold buffer empty) or a redirect occurs, assert `imem_req` with `imem_addr`=PC → BUSY.
  - BUSY: request held with a stable address until ack.
    - On ack with no redirect: route the response, PC += 4. If issue is allowed after routing, the next request is issued back-to-back (stay BUSY); otherwise → IDLE.
    - Redirect without ack → DRAIN.
    - Redirect with ack: response discarded; target issued next cycle (BUSY).
  - DRAIN: request kept at the old address until ack; response discarded; then issue PC (the target) → BUSY. A further redirect in DRAIN only updates PC.
- Response routing on ack:
  - If the output register is empty or being consumed (`stall`=0), load `if_*` (`if_pc` = request address).
  - Otherwise load the one-entry hold buffer.
  - The output register reloads from the hold buffer when consumed.
  - Order is preserved; no loss or duplication.
- At most one request outstanding. Hold buffer full ⇒ no issue.

## Timing
- Reset values:
  - `imem_req`=0, `imem_addr`=`RESET_PC`, PC=`RESET_PC`.
  - `if_valid`=0, `if_pc`=0, `if_instr`=0.
  - Hold buffer empty; `redirect_count`=0; state IDLE.
  - Flushes forced 0 while `rst_n`=0.
- First `imem_req` is high after the first rising edge with `rst_n`=1.
- Ack in cycle N ⇒ `if_valid` at N+1. A zero-wait memory sustains 1 instruction/cycle.
- Redirect in cycle N:
  - Flushes in N.
  - `imem_addr`=target at N+1 if nothing is outstanding or ack is in N.
  - Otherwise at the edge after the draining ack.
- Reset asserted mid-transfer: all state returns to reset values immediately; the pending ack is ignored.

## Structure
- Add `FETCH_STATE_*` encodings and `FETCH_STATE_BITS_COUNT` to `constants.sv`.
- Reuse the existing `PC_SRC_*` / `PC_SRC_BITS_COUNT` definitions from `constants.sv`.
- One sub-module: `redirect_target_gen`, combinational target computation.
- FSM, PC, output register, hold buffer and counter stay in the top.

## Test plan
- Reset with `RESET_PC`=0x1000, ack tied 1 → `imem_addr` 0x1000, 0x1004, 0x1008 on consecutive cycles; `if_valid`=1 with `if_pc` one cycle behind.
- JAL: `pc_source`=PC_PLUS_IMM, `ex_pc`=0x1004, `ex_imm`=0x20 → both flushes in the same cycle; next cycle `imem_addr`=0x1024, `if_valid`=0, `redirect_count`=1.
- JALR: `ex_gpr`=0x2003, `ex_imm`=4 → target 0x2006.
- Ack delayed 3 cycles, redirect to 0x3000 in cycle 1 of the wait → `imem_req` held at the old address until ack; that response produces no `if_valid`; the next request is at 0x3000.
- `stall`=1 for 4 cycles while acks arrive:
  - `if_*` frozen.
  - Hold buffer captures one response; no further `imem_req`.
  - After release, instructions at consecutive PCs are delivered in order without gaps or duplicates.
- Deassert `rst_n` asynchronously during BUSY → `imem_req`=0 and `redirect_count`=0 immediately; fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/fetch_redirect_controller_pkg.sv
// Shared encodings for the fetch/redirect controller: next-PC selectors,
// fetch FSM states and a small address helper.
package fetch_redirect_controller_pkg;

    localparam int PC_SRC_BITS_COUNT = 2;

    localparam logic [PC_SRC_BITS_COUNT-1:0] PC_SRC_PC_PLUS_4    = 2'd0;
    localparam logic [PC_SRC_BITS_COUNT-1:0] PC_SRC_PC_PLUS_IMM  = 2'd1;
    localparam logic [PC_SRC_BITS_COUNT-1:0] PC_SRC_GPR_PLUS_IMM = 2'd2;

    localparam int FETCH_STATE_BITS_COUNT = 2;

    typedef enum logic [FETCH_STATE_BITS_COUNT-1:0] {
        FETCH_STATE_IDLE  = 2'd0,
        FETCH_STATE_BUSY  = 2'd1,
        FETCH_STATE_DRAIN = 2'd2
    } fetch_state_t;

    localparam logic [31:0] INSTR_BYTES = 32'd4;

    // Register-indirect jump targets always have bit 0 cleared.
    function automatic logic [31:0] clearLsb(input logic [31:0] addr);
        return {addr[31:1], 1'b0};
    endfunction

endpackage

// File: rtl/fetch_redirect_controller_if.sv
// Single-outstanding request/ack instruction-memory channel.
// The fetch controller is the master, the memory the slave.
interface fetch_redirect_controller_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_redirect_controller_redirect_target_gen.sv
// Combinational redirect target for the instruction resolved in execute.
module redirect_target_gen
    import fetch_redirect_controller_pkg::*;
(
    input  logic [PC_SRC_BITS_COUNT-1:0] i_pcSource,
    input  logic [31:0]                  i_exPc,
    input  logic [31:0]                  i_exImm,
    input  logic [31:0]                  i_exGpr,
    output logic [31:0]                  o_target
);

    logic [31:0] w_pcSum;
    logic [31:0] w_gprSum;
    logic [31:0] w_pcNext;

    assign w_pcSum  = i_exPc + i_exImm;
    assign w_gprSum = i_exGpr + i_exImm;
    assign w_pcNext = i_exPc + INSTR_BYTES;

    // Unused selector encodings fall back to the sequential successor.
    always_comb begin
        o_target = w_pcNext;
        case (i_pcSource)
            PC_SRC_PC_PLUS_IMM:  o_target = w_pcSum;
            PC_SRC_GPR_PLUS_IMM: o_target = clearLsb(w_gprSum);
            PC_SRC_PC_PLUS_4:    o_target = w_pcNext;
            default:             o_target = w_pcNext;
        endcase
    end

endmodule

// File: rtl/fetch_redirect_controller.sv
// Owns the PC, sequences single-outstanding instruction fetch, buffers one
// response against decode stalls and applies execute-stage redirects.
module fetch_redirect_controller
    import fetch_redirect_controller_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [PC_SRC_BITS_COUNT-1:0] pc_source,
    input  logic                         branch_taken,
    input  logic                         ex_valid,
    input  logic [31:0]                  ex_pc,
    input  logic [31:0]                  ex_imm,
    input  logic [31:0]                  ex_gpr,
    input  logic                         stall,
    fetch_redirect_controller_if.master  imem,
    output logic                         if_valid,
    output logic [31:0]                  if_pc,
    output logic [31:0]                  if_instr,
    output logic                         flush_if_id,
    output logic                         flush_id_ex,
    output logic [31:0]                  redirect_count
);

    fetch_state_t r_state;
    logic [31:0]  r_pc;
    logic         r_req;
    logic [31:0]  r_addr;

    logic         r_outValid;
    logic [31:0]  r_outPc;
    logic [31:0]  r_outInstr;
    logic         r_holdValid;
    logic [31:0]  r_holdPc;
    logic [31:0]  r_holdInstr;

    logic [31:0]  r_redirectCount;

    logic [31:0]  w_target;
    logic [31:0]  w_pcNext;
    logic         w_redirect;
    logic         w_ack;
    logic         w_accept;
    logic         w_holdNextValid;
    logic         w_issueAfterAck;

    redirect_target_gen u_targetGen (
        .i_pcSource (pc_source),
        .i_exPc     (ex_pc),
        .i_exImm    (ex_imm),
        .i_exGpr    (ex_gpr),
        .o_target   (w_target)
    );

    assign w_redirect = ex_valid & branch_taken;
    assign w_ack      = r_req & imem.imem_ack;
    assign w_pcNext   = r_pc + INSTR_BYTES;

    // Only responses to a live request are kept; DRAIN acks belong to a
    // fetch that a redirect already made stale.
    assign w_accept = w_ack & (r_state == FETCH_STATE_BUSY);

    assign w_holdNextValid = stall ? (r_holdValid | (w_accept & r_outValid))
                                   : (r_holdValid & w_accept);
    assign w_issueAfterAck = ~stall & ~w_holdNextValid;

    assign flush_if_id = w_redirect & rst_n;
    assign flush_id_ex = w_redirect & rst_n;

    assign imem.imem_req  = r_req;
    assign imem.imem_addr = r_addr;

    assign if_valid       = r_outValid;
    assign if_pc          = r_outPc;
    assign if_instr       = r_outInstr;
    assign redirect_count = r_redirectCount;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FETCH_STATE_IDLE;
            r_req   <= 1'b0;
            r_addr  <= RESET_PC;
            r_pc    <= RESET_PC;
        end else begin
            case (r_state)
                FETCH_STATE_IDLE: begin
                    if (w_redirect) begin
                        r_pc    <= w_target;
                        r_addr  <= w_target;
                        r_req   <= 1'b1;
                        r_state <= FETCH_STATE_BUSY;
                    end else if (!stall && !r_holdValid) begin
                        r_addr  <= r_pc;
                        r_req   <= 1'b1;
                        r_state <= FETCH_STATE_BUSY;
                    end
                end
                FETCH_STATE_BUSY: begin
                    if (w_redirect) begin
                        r_pc <= w_target;
                        if (w_ack) begin
                            r_addr <= w_target;
                            r_req  <= 1'b1;
                        end else begin
                            r_state <= FETCH_STATE_DRAIN;
                        end
                    end else if (w_ack) begin
                        r_pc <= w_pcNext;
                        if (w_issueAfterAck) begin
                            r_addr <= w_pcNext;
                            r_req  <= 1'b1;
                        end else begin
                            r_req   <= 1'b0;
                            r_state <= FETCH_STATE_IDLE;
                        end
                    end
                end
                FETCH_STATE_DRAIN: begin
                    // The address stays on the stale fetch until memory lets go.
                    if (w_ack) begin
                        r_addr  <= w_redirect ? w_target : r_pc;
                        r_req   <= 1'b1;
                        r_state <= FETCH_STATE_BUSY;
                    end
                    if (w_redirect) begin
                        r_pc <= w_target;
                    end
                end
                default: begin
                    r_req   <= 1'b0;
                    r_state <= FETCH_STATE_IDLE;
                end
            endcase
        end
    end

    // Output register in front of IF/ID plus a one-entry skid buffer; the
    // older entry always leaves first so delivery order matches fetch order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outValid  <= 1'b0;
            r_outPc     <= 32'd0;
            r_outInstr  <= 32'd0;
            r_holdValid <= 1'b0;
            r_holdPc    <= 32'd0;
            r_holdInstr <= 32'd0;
        end else if (w_redirect) begin
            r_outValid  <= 1'b0;
            r_outPc     <= 32'd0;
            r_outInstr  <= 32'd0;
            r_holdValid <= 1'b0;
            r_holdPc    <= 32'd0;
            r_holdInstr <= 32'd0;
        end else if (!stall) begin
            if (r_holdValid) begin
                r_outValid  <= 1'b1;
                r_outPc     <= r_holdPc;
                r_outInstr  <= r_holdInstr;
                r_holdValid <= w_accept;
                if (w_accept) begin
                    r_holdPc    <= r_addr;
                    r_holdInstr <= imem.imem_rdata;
                end
            end else if (w_accept) begin
                r_outValid <= 1'b1;
                r_outPc    <= r_addr;
                r_outInstr <= imem.imem_rdata;
            end else begin
                r_outValid <= 1'b0;
            end
        end else if (w_accept) begin
            if (!r_outValid && !r_holdValid) begin
                r_outValid <= 1'b1;
                r_outPc    <= r_addr;
                r_outInstr <= imem.imem_rdata;
            end else if (!r_holdValid) begin
                r_holdValid <= 1'b1;
                r_holdPc    <= r_addr;
                r_holdInstr <= imem.imem_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_redirectCount <= 32'd0;
        end else if (w_redirect) begin
            r_redirectCount <= r_redirectCount + 32'd1;
        end
    end

endmodule

// File: tb/tb_fetch_redirect_controller.sv
// Scoreboard bench for fetch_redirect_controller: directed redirect, drain,
// stall and async-reset scenarios against a variable-latency memory model.
module tb_fetch_redirect_controller;
    import fetch_redirect_controller_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_1000;

    logic                         clk;
    logic                         rst_n;
    logic [PC_SRC_BITS_COUNT-1:0] pcSource;
    logic                         branchTaken;
    logic                         exValid;
    logic [31:0]                  exPc;
    logic [31:0]                  exImm;
    logic [31:0]                  exGpr;
    logic                         stall;
    logic                         ifValid;
    logic [31:0]                  ifPc;
    logic [31:0]                  ifInstr;
    logic                         flushIfId;
    logic                         flushIdEx;
    logic [31:0]                  redirectCount;

    int          total = 0;
    int          bad   = 0;
    int          memLatency = 0;
    int          memCnt = 0;
    logic [31:0] expQ[$];

    fetch_redirect_controller_if ifc ();

    fetch_redirect_controller #(.RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pc_source      (pcSource),
        .branch_taken   (branchTaken),
        .ex_valid       (exValid),
        .ex_pc          (exPc),
        .ex_imm         (exImm),
        .ex_gpr         (exGpr),
        .stall          (stall),
        .imem           (ifc),
        .if_valid       (ifValid),
        .if_pc          (ifPc),
        .if_instr       (ifInstr),
        .flush_if_id    (flushIfId),
        .flush_id_ex    (flushIdEx),
        .redirect_count (redirectCount)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] instrOf(input logic [31:0] addr);
        return addr ^ 32'h5A5A_0013;
    endfunction

    // Memory: acks once a request has been held for memLatency cycles.
    initial begin
        ifc.imem_ack   = 1'b0;
        ifc.imem_rdata = 32'd0;
        forever begin
            @(negedge clk);
            if (!ifc.imem_req) begin
                memCnt         = 0;
                ifc.imem_ack   = 1'b0;
                ifc.imem_rdata = 32'hDEAD_DEAD;
            end else begin
                if (ifc.imem_ack) memCnt = 0;
                if (memCnt >= memLatency) begin
                    ifc.imem_ack   = 1'b1;
                    ifc.imem_rdata = instrOf(ifc.imem_addr);
                end else begin
                    ifc.imem_ack   = 1'b0;
                    ifc.imem_rdata = 32'hDEAD_DEAD;
                    memCnt++;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    // Monitor: every instruction actually taken by IF/ID is popped and compared.
    initial begin
        logic [31:0] expPc;
        forever begin
            @(negedge clk);
            #3;
            if (rst_n && ifValid && !stall && !flushIfId) begin
                if (expQ.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected delivery: got if_pc 0x%08h expected none", ifPc);
                end else begin
                    expPc = expQ.pop_front();
                    checkOutput("sb if_pc", ifPc, expPc);
                    checkOutput("sb if_instr", ifInstr, instrOf(expPc));
                end
            end
        end
    end

    task automatic applyStimulus(input logic exv, input logic bt,
                                 input logic [PC_SRC_BITS_COUNT-1:0] src,
                                 input logic [31:0] pc, input logic [31:0] imm,
                                 input logic [31:0] gpr, input logic stl);
        @(negedge clk);
        exValid     = exv;
        branchTaken = bt;
        pcSource    = src;
        exPc        = pc;
        exImm       = imm;
        exGpr       = gpr;
        stall       = stl;
        #2;
    endtask

    task automatic applyIdle(input logic stl);
        applyStimulus(1'b0, 1'b0, PC_SRC_PC_PLUS_4, 32'd0, 32'd0, 32'd0, stl);
    endtask

    task automatic doReset(input int lat);
        @(negedge clk);
        rst_n       = 1'b0;
        memLatency  = lat;
        exValid     = 1'b0;
        branchTaken = 1'b0;
        stall       = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #2;
        checkOutput("post-reset imem_req", 32'(ifc.imem_req), 32'd0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n       = 1'b0;
        exValid     = 1'b0;
        branchTaken = 1'b0;
        pcSource    = PC_SRC_PC_PLUS_4;
        exPc        = 32'd0;
        exImm       = 32'd0;
        exGpr       = 32'd0;
        stall       = 1'b0;
        memLatency  = 0;

        // Scenario A: reset values, streaming, JAL, JALR
        repeat (2) @(negedge clk);
        exValid     = 1'b1;
        branchTaken = 1'b1;
        #2;
        checkOutput("reset flush_if_id", 32'(flushIfId), 32'd0);
        checkOutput("reset flush_id_ex", 32'(flushIdEx), 32'd0);
        checkOutput("reset imem_req", 32'(ifc.imem_req), 32'd0);
        checkOutput("reset imem_addr", ifc.imem_addr, RST_PC);
        checkOutput("reset if_valid", 32'(ifValid), 32'd0);
        checkOutput("reset if_pc", ifPc, 32'd0);
        checkOutput("reset if_instr", ifInstr, 32'd0);
        checkOutput("reset redirect_count", redirectCount, 32'd0);
        @(negedge clk);
        exValid     = 1'b0;
        branchTaken = 1'b0;
        rst_n       = 1'b1;
        expQ.push_back(32'h1000);
        expQ.push_back(32'h1004);
        expQ.push_back(32'h1024);
        expQ.push_back(32'h2006);

        applyIdle(1'b0);
        checkOutput("A first imem_req", 32'(ifc.imem_req), 32'd1);
        checkOutput("A addr 1000", ifc.imem_addr, 32'h1000);
        checkOutput("A first if_valid", 32'(ifValid), 32'd0);
        applyIdle(1'b0);
        checkOutput("A addr 1004", ifc.imem_addr, 32'h1004);
        checkOutput("A if_valid", 32'(ifValid), 32'd1);
        checkOutput("A if_pc lag", ifPc, 32'h1000);
        applyIdle(1'b0);
        checkOutput("A addr 1008", ifc.imem_addr, 32'h1008);
        checkOutput("A if_pc 1004", ifPc, 32'h1004);
        applyStimulus(1'b1, 1'b1, PC_SRC_PC_PLUS_IMM, 32'h1004, 32'h20, 32'd0, 1'b0);
        checkOutput("JAL flush_if_id", 32'(flushIfId), 32'd1);
        checkOutput("JAL flush_id_ex", 32'(flushIdEx), 32'd1);
        applyIdle(1'b0);
        checkOutput("JAL imem_addr", ifc.imem_addr, 32'h1024);
        checkOutput("JAL if_valid", 32'(ifValid), 32'd0);
        checkOutput("JAL redirect_count", redirectCount, 32'd1);
        applyIdle(1'b0);
        checkOutput("A addr 1028", ifc.imem_addr, 32'h1028);
        applyStimulus(1'b1, 1'b1, PC_SRC_GPR_PLUS_IMM, 32'h1024, 32'd4, 32'h2003, 1'b0);
        checkOutput("JALR flush_if_id", 32'(flushIfId), 32'd1);
        checkOutput("JALR flush_id_ex", 32'(flushIdEx), 32'd1);
        applyIdle(1'b0);
        checkOutput("JALR imem_addr", ifc.imem_addr, 32'h2006);
        checkOutput("JALR if_valid", 32'(ifValid), 32'd0);
        checkOutput("JALR redirect_count", redirectCount, 32'd2);
        applyIdle(1'b0);
        checkOutput("A addr 200a", ifc.imem_addr, 32'h200A);
        checkOutput("A if_pc 2006", ifPc, 32'h2006);
        applyIdle(1'b1);
        applyIdle(1'b1);
        checkOutput("A stalled no issue", 32'(ifc.imem_req), 32'd0);
        checkOutput("A pending", 32'(expQ.size()), 32'd0);

        // Scenario B: redirect while a slow fetch is outstanding
        doReset(3);
        expQ.push_back(32'h3000);
        applyIdle(1'b0);
        checkOutput("B addr 1000", ifc.imem_addr, 32'h1000);
        applyStimulus(1'b1, 1'b1, PC_SRC_PC_PLUS_IMM, 32'h2F00, 32'h100, 32'd0, 1'b0);
        checkOutput("B flush_if_id", 32'(flushIfId), 32'd1);
        applyIdle(1'b0);
        checkOutput("B drain req", 32'(ifc.imem_req), 32'd1);
        checkOutput("B drain addr", ifc.imem_addr, 32'h1000);
        applyIdle(1'b0);
        checkOutput("B drain addr at ack", ifc.imem_addr, 32'h1000);
        applyIdle(1'b0);
        checkOutput("B target addr", ifc.imem_addr, 32'h3000);
        checkOutput("B target req", 32'(ifc.imem_req), 32'd1);
        checkOutput("B stale dropped", 32'(ifValid), 32'd0);
        applyIdle(1'b0);
        applyIdle(1'b0);
        checkOutput("B wait if_valid", 32'(ifValid), 32'd0);
        applyIdle(1'b0);
        checkOutput("B addr held", ifc.imem_addr, 32'h3000);
        applyIdle(1'b0);
        checkOutput("B if_pc 3000", ifPc, 32'h3000);
        checkOutput("B next addr", ifc.imem_addr, 32'h3004);
        checkOutput("B redirect_count", redirectCount, 32'd1);
        applyIdle(1'b1);
        applyIdle(1'b1);
        checkOutput("B pending", 32'(expQ.size()), 32'd0);

        // Scenario C: four stalled cycles with a zero-wait memory
        doReset(0);
        expQ.push_back(32'h1000);
        expQ.push_back(32'h1004);
        expQ.push_back(32'h1008);
        expQ.push_back(32'h100C);
        applyIdle(1'b0);
        applyIdle(1'b0);
        checkOutput("C if_pc 1000", ifPc, 32'h1000);
        applyIdle(1'b1);
        checkOutput("C stall if_pc", ifPc, 32'h1004);
        for (int i = 0; i < 3; i++) begin
            applyIdle(1'b1);
            checkOutput("C frozen if_valid", 32'(ifValid), 32'd1);
            checkOutput("C frozen if_pc", ifPc, 32'h1004);
            checkOutput("C frozen if_instr", ifInstr, instrOf(32'h1004));
            checkOutput("C no issue", 32'(ifc.imem_req), 32'd0);
        end
        applyIdle(1'b0);
        checkOutput("C release if_pc", ifPc, 32'h1004);
        checkOutput("C hold blocks issue", 32'(ifc.imem_req), 32'd0);
        applyIdle(1'b0);
        checkOutput("C hold drained", ifPc, 32'h1008);
        applyIdle(1'b0);
        checkOutput("C resume addr", ifc.imem_addr, 32'h100C);
        checkOutput("C resume req", 32'(ifc.imem_req), 32'd1);
        applyIdle(1'b0);
        checkOutput("C if_pc 100c", ifPc, 32'h100C);
        applyIdle(1'b1);
        checkOutput("C pending", 32'(expQ.size()), 32'd0);

        // Scenario D: asynchronous reset while a fetch is in flight
        doReset(0);
        applyIdle(1'b0);
        checkOutput("D addr 1000", ifc.imem_addr, 32'h1000);
        applyStimulus(1'b1, 1'b1, PC_SRC_PC_PLUS_IMM, 32'h1000, 32'h40, 32'd0, 1'b0);
        applyIdle(1'b0);
        checkOutput("D addr 1040", ifc.imem_addr, 32'h1040);
        checkOutput("D redirect_count", redirectCount, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("D async imem_req", 32'(ifc.imem_req), 32'd0);
        checkOutput("D async redirect_count", redirectCount, 32'd0);
        checkOutput("D async imem_addr", ifc.imem_addr, RST_PC);
        checkOutput("D async if_valid", 32'(ifValid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #2;
        checkOutput("D restart idle", 32'(ifc.imem_req), 32'd0);
        applyIdle(1'b0);
        checkOutput("D restart req", 32'(ifc.imem_req), 32'd1);
        checkOutput("D restart addr", ifc.imem_addr, RST_PC);
        applyIdle(1'b1);
        checkOutput("D restart if_pc", ifPc, RST_PC);
        checkOutput("D pending", 32'(expQ.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
